// File: rtl/gpio_default_serializer.sv
// gpio_default_serializer
//
// Takes the hard-wired 1.8V-domain default bits from the constant tie-off
// cells and shifts them MSB-first into the GPIO serial configuration chain.
// The block generates the chain data, shift clock and load strobe.
//
// Each bit takes DIV cycles with serial_clock low (SETUP) and then DIV cycles
// with serial_clock high (HIGH). After the last bit, serial_load is held high
// for DIV cycles (LOAD). One transfer therefore occupies 2*DIV*WIDTH + DIV
// cycles, and busy is high for exactly those cycles.
//
// Parameters:
//   WIDTH  number of default bits per transfer (>= 2)
//   DIV    system clocks per serial_clock phase (>= 1)
//
// Ports:
//   wb_clk_i         system clock, all state on the rising edge
//   wb_rst_i         asynchronous active-high reset
//   defaults         default bits from the tie-offs, latched at start
//   start            single-cycle transfer request, ignored while busy
//   serial_data_out  chain data, MSB first
//   serial_clock     chain shift clock
//   serial_load      chain load strobe, high for DIV cycles after the last bit
//   busy             high from the accepted start until LOAD ends
//   done             one-cycle pulse in the first idle cycle after LOAD
//
// Optional feature macro: GPIO_DEFAULT_AUTOLOAD_EN
//   When this macro is defined, an internal request fires once on the first
//   clock after reset is released. That request is ORed with start.
module gpio_default_serializer #(
    parameter int WIDTH = 13,
    parameter int DIV   = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] defaults,
    input  logic             start,
    output logic             serial_data_out,
    output logic             serial_clock,
    output logic             serial_load,
    output logic             busy,
    output logic             done
);

    localparam int PH_W = $clog2(DIV) + 1;
    localparam int BC_W = $clog2(WIDTH) + 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] shadow_next;
    logic [BC_W-1:0]  bit_cnt_reg;
    logic [PH_W-1:0]  phase_reg;
    logic             sdo_reg;
    logic             sclk_reg;
    logic             load_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             start_req;
    logic             phase_last;

    assign phase_last = (phase_reg == PH_LAST);

    // The shadow register shifts left by one bit and is filled with zero.
    assign shadow_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shadow_next[gi] = shadow_reg[gi-1];
        end
    endgenerate

`ifdef GPIO_DEFAULT_AUTOLOAD_EN
    // This register is set during reset and clears on the first clock after
    // release. It raises exactly one request for each reset release.
    logic autoload_pending_reg;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            autoload_pending_reg <= 1'b1;
        end else begin
            autoload_pending_reg <= 1'b0;
        end
    end

    assign start_req = start | autoload_pending_reg;
`else
    assign start_req = start;
`endif

    // Each output is registered together with the state it belongs to.
    // The outputs therefore always describe the current state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            bit_cnt_reg <= '0;
            phase_reg   <= '0;
            sdo_reg     <= 1'b0;
            sclk_reg    <= 1'b0;
            load_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sdo_reg  <= 1'b0;
                    sclk_reg <= 1'b0;
                    load_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (start_req) begin
                        shadow_reg  <= defaults;
                        bit_cnt_reg <= BC_FULL;
                        phase_reg   <= '0;
                        state_reg   <= SETUP;
                        busy_reg    <= 1'b1;
                        // Put the MSB on the line in the first SETUP cycle.
                        sdo_reg     <= defaults[WIDTH-1];
                    end
                end

                SETUP: begin
                    sdo_reg <= shadow_reg[WIDTH-1];
                    if (phase_last) begin
                        phase_reg <= '0;
                        sclk_reg  <= 1'b1;
                        state_reg <= HIGH;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end

                HIGH: begin
                    if (phase_last) begin
                        phase_reg   <= '0;
                        sclk_reg    <= 1'b0;
                        shadow_reg  <= shadow_next;
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        if (bit_cnt_reg == BC_ONE) begin
                            sdo_reg   <= 1'b0;
                            load_reg  <= 1'b1;
                            state_reg <= LOAD;
                        end else begin
                            sdo_reg   <= shadow_next[WIDTH-1];
                            state_reg <= SETUP;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end

                LOAD: begin
                    if (phase_last) begin
                        phase_reg <= '0;
                        load_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign serial_data_out = sdo_reg;
    assign serial_clock    = sclk_reg;
    assign serial_load     = load_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;

endmodule
